// File: rtl/fft_frame_pkg.sv
// fft_frame_pkg
// Shared definitions for the FFT frame controller:
//   - state_t   : frame controller FSM encoding
//   - NFFT_LSB / NFFT_WIDTH / FWD_LSB : bit positions inside the core config word
//   - clogb2    : ceiling log2 helper for counter sizing
package fft_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_CFG_WAIT,
    S_WR,
    S_ZP,
    S_DISCARD,
    S_RD
  } state_t;

  localparam int NFFT_LSB   = 0;
  localparam int NFFT_WIDTH = 5;
  localparam int FWD_LSB    = 8;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_ctrl_slice.sv
// axis_reg_slice
// Single-stage AXI-Stream register. The register loads whenever it is empty
// or its current beat is being taken downstream, so a full-rate stream passes
// without bubbles while s_ready never depends on s_valid.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   s_data/s_valid/s_ready upstream side
//   m_data/m_valid/m_ready downstream side
module axis_reg_slice #(
  parameter int WIDTH = 65
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  assign s_ready = !m_valid || m_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (s_ready) begin
      // valid drops after a handshake unless a new beat loads in the same cycle
      m_valid <= s_valid;
      if (s_valid) m_data <= s_data;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Frame controller between a sample stream and a streaming FFT core. For each
// accepted start it sends one config word (length + per-channel direction),
// waits out the core config latency, then forwards exactly 2**log2_len beats
// to the core: short input frames are zero-padded, long ones are truncated and
// the excess input is absorbed. Core output is passed straight downstream with
// a running bin index; done pulses once both directions of the frame finish.
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   start, log2_len, fwd_inv      frame request (length/direction latched on start)
//   s_axis_*                      input samples
//   m_axis_cfg_*                  config word to the core
//   m_axis_fft_*                  data to the core
//   s_axis_fft_*                  data from the core
//   m_axis_*, m_axis_index        downstream output and bin index
//   busy, done, err_len, err_trunc status
module fft_frame_ctrl
  import fft_frame_pkg::*;
#(
  parameter int MAX_LOG2_LEN   = 13,
  parameter int MIN_LOG2_LEN   = 3,
  parameter int CHANNELS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int INDEX_WIDTH    = 32,
  parameter int CONFIG_LATENCY = 16,
  parameter int CFG_WIDTH      = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           start,
  input  logic [4:0]                     log2_len,
  input  logic [CHANNELS-1:0]            fwd_inv,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [CFG_WIDTH-1:0]           m_axis_cfg_tdata,
  output logic                           m_axis_cfg_tvalid,
  input  logic                           m_axis_cfg_tready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_fft_tdata,
  output logic                           m_axis_fft_tvalid,
  output logic                           m_axis_fft_tlast,
  input  logic                           m_axis_fft_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_fft_tdata,
  input  logic                           s_axis_fft_tvalid,
  input  logic                           s_axis_fft_tlast,
  output logic                           s_axis_fft_tready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic [INDEX_WIDTH-1:0]         m_axis_index,
  output logic                           busy,
  output logic                           done,
  output logic                           err_len,
  output logic                           err_trunc
);

  localparam int BEAT_W = CHANNELS * DATA_WIDTH;
  localparam int WAIT_W = clogb2(CONFIG_LATENCY) + 1;

  // One extra bit so that 2**MAX_LOG2_LEN itself is representable.
  typedef logic [MAX_LOG2_LEN:0] count_t;

  state_t               state, state_next;
  count_t               remaining;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [CFG_WIDTH-1:0] cfg_word, cfg_build;
  logic [BEAT_W-1:0]    slice_data;
  logic                 slice_valid, slice_last, load_ok;
  logic                 len_ok, last_beat, accept_start, dec_remaining, set_trunc;
  logic                 done_next, err_len_next;
  logic                 out_hs, out_done, out_done_now;

  assign len_ok    = (int'(log2_len) >= MIN_LOG2_LEN) && (int'(log2_len) <= MAX_LOG2_LEN);
  assign last_beat = (remaining == count_t'(1));

  // Output frame counts as complete if its tlast is being taken this cycle.
  assign out_hs       = s_axis_fft_tvalid && m_axis_tready;
  assign out_done_now = out_done || (out_hs && s_axis_fft_tlast);

  always_comb begin
    cfg_build = '0;
    cfg_build[NFFT_LSB +: NFFT_WIDTH] = log2_len;
    cfg_build[FWD_LSB +: CHANNELS]    = fwd_inv;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    slice_valid   = 1'b0;
    slice_data    = '0;
    slice_last    = 1'b0;
    accept_start  = 1'b0;
    dec_remaining = 1'b0;
    set_trunc     = 1'b0;
    done_next     = 1'b0;
    err_len_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            accept_start = 1'b1;
            state_next   = S_CONFIG;
          end else begin
            err_len_next = 1'b1;
          end
        end
      end
      S_CONFIG: begin
        if (m_axis_cfg_tready) state_next = S_CFG_WAIT;
      end
      S_CFG_WAIT: begin
        // wait_cnt runs 0..CONFIG_LATENCY-2, i.e. CONFIG_LATENCY-1 cycles here
        if (int'(wait_cnt) + 2 >= CONFIG_LATENCY) state_next = S_WR;
      end
      S_WR: begin
        s_axis_tready = load_ok;
        slice_valid   = s_axis_tvalid;
        slice_data    = s_axis_tdata;
        slice_last    = last_beat;
        if (s_axis_tvalid && load_ok) begin
          dec_remaining = 1'b1;
          if (last_beat) begin
            if (s_axis_tlast) begin
              state_next = S_RD;
            end else begin
              set_trunc  = 1'b1;
              state_next = S_DISCARD;
            end
          end else if (s_axis_tlast) begin
            state_next = S_ZP;
          end
        end
      end
      S_ZP: begin
        slice_valid = 1'b1;
        slice_last  = last_beat;
        if (load_ok) begin
          dec_remaining = 1'b1;
          if (last_beat) state_next = S_RD;
        end
      end
      S_DISCARD: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          if (out_done_now) begin
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_RD;
          end
        end
      end
      S_RD: begin
        if (out_done_now) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      remaining <= '0;
      wait_cnt  <= '0;
      cfg_word  <= '0;
      err_trunc <= 1'b0;
      out_done  <= 1'b0;
      done      <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      done    <= done_next;
      err_len <= err_len_next;

      if (state == S_CFG_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                     wait_cnt <= '0;

      if (accept_start)       remaining <= count_t'(1) << log2_len;
      else if (dec_remaining) remaining <= remaining - 1'b1;

      if (accept_start) cfg_word <= cfg_build;

      if (accept_start)   err_trunc <= 1'b0;
      else if (set_trunc) err_trunc <= 1'b1;

      if (accept_start)                    out_done <= 1'b0;
      else if (out_hs && s_axis_fft_tlast) out_done <= 1'b1;
    end
  end

  // Bin index follows downstream handshakes and rewinds after each frame.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_index <= '0;
    end else if (out_hs) begin
      if (s_axis_fft_tlast) m_axis_index <= '0;
      else                  m_axis_index <= m_axis_index + 1'b1;
    end
  end

  axis_reg_slice #(
    .WIDTH(BEAT_W + 1)
  ) u_core_slice (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_data  ({slice_last, slice_data}),
    .s_valid (slice_valid),
    .s_ready (load_ok),
    .m_data  ({m_axis_fft_tlast, m_axis_fft_tdata}),
    .m_valid (m_axis_fft_tvalid),
    .m_ready (m_axis_fft_tready)
  );

  assign m_axis_cfg_tvalid = (state == S_CONFIG);
  assign m_axis_cfg_tdata  = cfg_word;
  assign busy              = (state != S_IDLE);

  assign m_axis_tdata      = s_axis_fft_tdata;
  assign m_axis_tvalid     = s_axis_fft_tvalid;
  assign m_axis_tlast      = s_axis_fft_tlast;
  assign s_axis_fft_tready = m_axis_tready;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
// Directed bench for fft_frame_ctrl with default parameters (CHANNELS=2,
// DATA_WIDTH=32, CONFIG_LATENCY=16). Monitors log every beat seen toward the
// core and downstream; the main sequence compares those logs and the status
// outputs against hand-derived values.
module tb_fft_frame_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [4:0]  log2_len;
  logic [1:0]  fwd_inv;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [15:0] m_axis_cfg_tdata;
  logic        m_axis_cfg_tvalid, m_axis_cfg_tready;
  logic [63:0] m_axis_fft_tdata;
  logic        m_axis_fft_tvalid, m_axis_fft_tlast, m_axis_fft_tready;
  logic [63:0] s_axis_fft_tdata;
  logic        s_axis_fft_tvalid, s_axis_fft_tlast, s_axis_fft_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0] m_axis_index;
  logic        busy, done, err_len, err_trunc;

  int n_compared = 0;
  int n_failed   = 0;

  logic [64:0] core_log [256];
  int          core_cnt = 0;
  logic [31:0] idx_log  [256];
  logic [63:0] mdat_log [256];
  int          m_cnt    = 0;
  int          done_cnt = 0;

  fft_frame_ctrl dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start             (start),
    .log2_len          (log2_len),
    .fwd_inv           (fwd_inv),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_axis_cfg_tdata  (m_axis_cfg_tdata),
    .m_axis_cfg_tvalid (m_axis_cfg_tvalid),
    .m_axis_cfg_tready (m_axis_cfg_tready),
    .m_axis_fft_tdata  (m_axis_fft_tdata),
    .m_axis_fft_tvalid (m_axis_fft_tvalid),
    .m_axis_fft_tlast  (m_axis_fft_tlast),
    .m_axis_fft_tready (m_axis_fft_tready),
    .s_axis_fft_tdata  (s_axis_fft_tdata),
    .s_axis_fft_tvalid (s_axis_fft_tvalid),
    .s_axis_fft_tlast  (s_axis_fft_tlast),
    .s_axis_fft_tready (s_axis_fft_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .m_axis_index      (m_axis_index),
    .busy              (busy),
    .done              (done),
    .err_len           (err_len),
    .err_trunc         (err_trunc)
  );

  always #5 aclk = ~aclk;

  // Log every beat accepted by the core
  always @(posedge aclk) begin
    if (aresetn && m_axis_fft_tvalid && m_axis_fft_tready) begin
      core_log[core_cnt[7:0]] <= {m_axis_fft_tlast, m_axis_fft_tdata};
      core_cnt <= core_cnt + 1;
    end
  end

  // Log every downstream beat with its bin index
  always @(posedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      idx_log[m_cnt[7:0]]  <= m_axis_index;
      mdat_log[m_cnt[7:0]] <= m_axis_tdata;
      m_cnt <= m_cnt + 1;
    end
  end

  always @(posedge aclk) begin
    if (aresetn && done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [63:0] pattern(input logic [7:0] fid, input int i);
    return {fid, 24'(i), ~fid, 24'(i)};
  endfunction

  // Expected core beat: input data then zeros, tlast on the final beat
  function automatic logic [64:0] exp_core(input logic [7:0] fid, input int i,
                                           input int n_in, input int len);
    logic [63:0] d;
    d = (i < n_in) ? pattern(fid, i) : 64'h0;
    return {(i == len - 1), d};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic start_frame(input logic [4:0] len, input logic [1:0] fwd);
    start    = 1'b1;
    log2_len = len;
    fwd_inv  = fwd;
    tick();
    start    = 1'b0;
  endtask

  task automatic cfg_handshake();
    int g;
    g = 0;
    while (!m_axis_cfg_tvalid && g < 20) begin
      tick();
      g++;
    end
    if (g >= 20) check_output("cfg_valid_timeout", 0, 1);
    m_axis_cfg_tready = 1'b1;
    tick();
    m_axis_cfg_tready = 1'b0;
  endtask

  // Drive input beats first..first+n-1; tlast on the final one if last_at_end
  task automatic apply_stimulus(input logic [7:0] fid, input int first, input int n,
                                input bit last_at_end);
    int g;
    for (int i = first; i < first + n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pattern(fid, i);
      s_axis_tlast  = last_at_end && (i == first + n - 1);
      g = 0;
      while (!s_axis_tready && g < 200) begin
        tick();
        g++;
      end
      if (g >= 200) begin
        check_output("in_ready_timeout", 0, 1);
        break;
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_core(input int target);
    int g;
    g = 0;
    while (core_cnt < target && g < 200) begin
      tick();
      g++;
    end
    check_output("core_beat_count", core_cnt, target);
  endtask

  task automatic check_core(input string tag, input logic [7:0] fid, input int base,
                            input int n_in, input int len);
    for (int i = 0; i < len; i++)
      check_output(tag, core_log[(base + i) % 256], exp_core(fid, i, n_in, len));
  endtask

  // Core output frame of n beats; downstream ready optionally stalls randomly
  task automatic send_core_frame(input logic [7:0] fid, input int n, input bit stalls);
    int  g;
    logic hs;
    for (int b = 0; b < n; b++) begin
      s_axis_fft_tvalid = 1'b1;
      s_axis_fft_tdata  = pattern(fid ^ 8'h80, b);
      s_axis_fft_tlast  = (b == n - 1);
      g = 0;
      do begin
        m_axis_tready = (stalls && g < 50) ? 1'($urandom_range(0, 1)) : 1'b1;
        hs = m_axis_tready;
        tick();
        g++;
      end while (!hs);
    end
    s_axis_fft_tvalid = 1'b0;
    s_axis_fft_tlast  = 1'b0;
    m_axis_tready     = 1'b1;
  endtask

  task automatic check_out_frame(input string tag, input logic [7:0] fid, input int base,
                                 input int n);
    for (int k = 0; k < n; k++) begin
      check_output({tag, "_index"}, idx_log[(base + k) % 256], 32'(k));
      check_output({tag, "_data"}, mdat_log[(base + k) % 256], pattern(fid ^ 8'h80, k));
    end
  endtask

  initial begin
    int core_base, m_base, done_base, n;

    aresetn           = 1'b0;
    start             = 1'b0;
    log2_len          = 5'd0;
    fwd_inv           = 2'b00;
    s_axis_tdata      = '0;
    s_axis_tvalid     = 1'b0;
    s_axis_tlast      = 1'b0;
    m_axis_cfg_tready = 1'b0;
    m_axis_fft_tready = 1'b1;
    s_axis_fft_tdata  = '0;
    s_axis_fft_tvalid = 1'b0;
    s_axis_fft_tlast  = 1'b0;
    m_axis_tready     = 1'b1;

    repeat (3) tick();
    $display("[TB] reset state");
    check_output("rst_busy", busy, 0);
    check_output("rst_cfg_valid", m_axis_cfg_tvalid, 0);
    check_output("rst_cfg_data", m_axis_cfg_tdata, 0);
    check_output("rst_fft_valid", m_axis_fft_tvalid, 0);
    check_output("rst_fft_last", m_axis_fft_tlast, 0);
    check_output("rst_fft_data", m_axis_fft_tdata, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err_len", err_len, 0);
    check_output("rst_err_trunc", err_trunc, 0);
    check_output("rst_index", m_axis_index, 0);
    aresetn = 1'b1;
    tick();

    // Frame A: exact-length 16-beat frame, downstream stalls
    $display("[TB] frame A: log2_len=4, 16 beats");
    core_base = core_cnt;
    m_base    = m_cnt;
    done_base = done_cnt;
    start_frame(5'd4, 2'b11);
    check_output("A_cfg_valid", m_axis_cfg_tvalid, 1);
    check_output("A_cfg_data", m_axis_cfg_tdata, 16'h0304);
    check_output("A_busy", busy, 1);
    tick();
    tick();
    check_output("A_cfg_hold", m_axis_cfg_tvalid, 1);
    m_axis_cfg_tready = 1'b1;
    tick();
    m_axis_cfg_tready = 1'b0;
    check_output("A_cfg_dropped", m_axis_cfg_tvalid, 0);
    n = 0;
    while (!s_axis_tready && n < 100) begin
      tick();
      n++;
    end
    check_output("A_cfg_wait_cycles", n, 15);
    apply_stimulus(8'h0A, 0, 16, 1'b1);
    wait_core(core_base + 16);
    check_core("A_core", 8'h0A, core_base, 16, 16);
    check_output("A_err_trunc", err_trunc, 0);
    check_output("A_busy_rd", busy, 1);
    send_core_frame(8'h0A, 16, 1'b1);
    repeat (3) tick();
    check_output("A_done_once", done_cnt, done_base + 1);
    check_output("A_out_beats", m_cnt, m_base + 16);
    check_out_frame("A_out", 8'h0A, m_base, 16);
    check_output("A_index_rewound", m_axis_index, 0);
    check_output("A_idle", busy, 0);

    // Frame B: 10 beats into a 32-point frame, zero padding
    $display("[TB] frame B: log2_len=5, 10 beats");
    core_base = core_cnt;
    m_base    = m_cnt;
    done_base = done_cnt;
    start_frame(5'd5, 2'b01);
    check_output("B_cfg_data", m_axis_cfg_tdata, 16'h0105);
    cfg_handshake();
    apply_stimulus(8'h0B, 0, 10, 1'b1);
    check_output("B_zp_ready", s_axis_tready, 0);
    tick();
    check_output("B_zp_ready2", s_axis_tready, 0);
    wait_core(core_base + 32);
    check_core("B_core", 8'h0B, core_base, 10, 32);
    check_output("B_err_trunc", err_trunc, 0);
    send_core_frame(8'h0B, 32, 1'b0);
    repeat (3) tick();
    check_output("B_done_once", done_cnt, done_base + 1);
    check_out_frame("B_out", 8'h0B, m_base, 32);
    check_output("B_idle", busy, 0);

    // Frame C: 12 beats into an 8-point frame, truncation
    $display("[TB] frame C: log2_len=3, 12 beats");
    core_base = core_cnt;
    m_base    = m_cnt;
    done_base = done_cnt;
    start_frame(5'd3, 2'b10);
    check_output("C_cfg_data", m_axis_cfg_tdata, 16'h0203);
    cfg_handshake();
    apply_stimulus(8'h0C, 0, 8, 1'b0);
    check_output("C_err_trunc_set", err_trunc, 1);
    check_output("C_discard_ready", s_axis_tready, 1);
    apply_stimulus(8'h0C, 8, 4, 1'b1);
    wait_core(core_base + 8);
    repeat (4) tick();
    check_output("C_core_no_extra", core_cnt, core_base + 8);
    check_core("C_core", 8'h0C, core_base, 12, 8);
    check_output("C_wait_output", busy, 1);
    check_output("C_no_early_done", done_cnt, done_base);
    send_core_frame(8'h0C, 8, 1'b1);
    repeat (3) tick();
    check_output("C_done_once", done_cnt, done_base + 1);
    check_out_frame("C_out", 8'h0C, m_base, 8);
    check_output("C_err_trunc_sticky", err_trunc, 1);

    // Rejected lengths on either side of the legal range
    $display("[TB] rejected lengths");
    start_frame(5'd2, 2'b11);
    check_output("L2_err_len", err_len, 1);
    check_output("L2_busy", busy, 0);
    check_output("L2_cfg_valid", m_axis_cfg_tvalid, 0);
    tick();
    check_output("L2_err_len_pulse", err_len, 0);
    start_frame(5'd14, 2'b11);
    check_output("L14_err_len", err_len, 1);
    check_output("L14_busy", busy, 0);
    check_output("L14_cfg_valid", m_axis_cfg_tvalid, 0);
    tick();
    check_output("L14_err_len_pulse", err_len, 0);
    check_output("L14_cfg_valid2", m_axis_cfg_tvalid, 0);
    check_output("L_err_trunc_kept", err_trunc, 1);

    // Reset in the middle of a write
    $display("[TB] reset mid-frame");
    start_frame(5'd4, 2'b11);
    check_output("R_err_trunc_cleared", err_trunc, 0);
    cfg_handshake();
    apply_stimulus(8'h0D, 0, 5, 1'b0);
    check_output("R_busy_before", busy, 1);
    aresetn = 1'b0;
    tick();
    check_output("R_busy", busy, 0);
    check_output("R_fft_valid", m_axis_fft_tvalid, 0);
    check_output("R_cfg_valid", m_axis_cfg_tvalid, 0);
    check_output("R_in_ready", s_axis_tready, 0);
    aresetn = 1'b1;
    tick();

    // Frame E: clean frame after reset
    $display("[TB] frame E: clean frame after reset");
    core_base = core_cnt;
    m_base    = m_cnt;
    done_base = done_cnt;
    start_frame(5'd4, 2'b11);
    check_output("E_cfg_data", m_axis_cfg_tdata, 16'h0304);
    cfg_handshake();
    apply_stimulus(8'h0E, 0, 16, 1'b1);
    wait_core(core_base + 16);
    check_core("E_core", 8'h0E, core_base, 16, 16);
    send_core_frame(8'h0E, 16, 1'b1);
    repeat (3) tick();
    check_output("E_done_once", done_cnt, done_base + 1);
    check_out_frame("E_out", 8'h0E, m_base, 16);
    check_output("E_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Runtime-configurable frame controller that sits between the ADC/chirp sample stream and an external streaming FFT core. It issues the core config word with a per-frame transform length and per-channel direction, then waits out the config latency. It forwards input samples, zero-pads short frames, truncates long ones, and passes the core output downstream with a bin index and a frame-done pulse. This generalises the fixed-length, forward-only FFT wrapper to a runtime length, per-channel direction and an overlength policy.

Parameters:
MAX_LOG2_LEN, 13, largest supported log2 transform length (max 8192 points)
MIN_LOG2_LEN, 3, smallest supported log2 transform length
CHANNELS, 2, parallel FFT channels
DATA_WIDTH, 32, complex sample width per channel (re/im packed)
INDEX_WIDTH, 32, width of output bin index
CONFIG_LATENCY, 16, cycles to wait after the config handshake before data is sent
CFG_WIDTH, 16, config word width (must be >= 8+CHANNELS)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
start  in  1  single-cycle frame request; sampled only in IDLE
log2_len  in  5  transform length for the frame; latched on start
fwd_inv  in  CHANNELS  per-channel direction (1 = forward); latched on start
s_axis_tdata  in  CHANNELS*DATA_WIDTH  input samples
s_axis_tvalid / s_axis_tlast  in  1  input handshake and frame end
s_axis_tready  out  1  input ready
m_axis_cfg_tdata  out  CFG_WIDTH  config word to the core
m_axis_cfg_tvalid  out  1  config valid; m_axis_cfg_tready in 1 from the core
m_axis_fft_tdata  out  CHANNELS*DATA_WIDTH  data to the core
m_axis_fft_tvalid / m_axis_fft_tlast  out  1  data to the core
m_axis_fft_tready  in  1  core data ready
s_axis_fft_tdata  in  CHANNELS*DATA_WIDTH  core output
s_axis_fft_tvalid / s_axis_fft_tlast  in  1  core output handshake
s_axis_fft_tready  out  1  ready toward the core
m_axis_tdata  out  CHANNELS*DATA_WIDTH  downstream output
m_axis_tvalid / m_axis_tlast  out  1  downstream handshake
m_axis_tready  in  1  downstream ready
m_axis_index  out  INDEX_WIDTH  bin index of the current m_axis beat
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame completion
err_len  out  1  one-cycle pulse when start is rejected
err_trunc  out  1  sticky flag: input exceeded the length; cleared on the next accepted start

Behaviour:
- Reset: FSM goes to IDLE. All valid, tlast, done, err_len, err_trunc and busy outputs are 0. Config and data registers are 0. m_axis_index is 0.
- States: IDLE, CONFIG, CFG_WAIT, WR, ZP, DISCARD, RD.
- IDLE: on start, if log2_len is outside [MIN_LOG2_LEN, MAX_LOG2_LEN], pulse err_len and stay in IDLE. Otherwise latch the length and direction, clear err_trunc, set remaining = 2^log2_len, and go to CONFIG.
- CONFIG: drive cfg_tvalid=1 with cfg_tdata[4:0]=log2_len, cfg_tdata[8+c]=fwd_inv[c], all other bits 0. Hold until cfg_tready, then go to CFG_WAIT.
- CFG_WAIT: count CONFIG_LATENCY-1 cycles, then go to WR.
- Output register to the core (single stage): loads when !m_axis_fft_tvalid | m_axis_fft_tready. tvalid clears on a handshake if nothing new loads.
- WR: s_axis_tready = the load condition. Each input beat loads the register and decrements remaining.
  - Beat that makes remaining 0: set fft_tlast. If that beat also has s_axis_tlast, go to RD; otherwise set err_trunc and go to DISCARD.
  - s_axis_tlast with remaining > 0 after the decrement: go to ZP.
- ZP: s_axis_tready=0. Load zeros whenever the register can load; tlast is set on the beat that makes remaining 0. Then go to RD.
- DISCARD: s_axis_tready=1 and beats are dropped. On s_axis_tlast, go to RD, or to IDLE with a done pulse if the output frame is already complete.
- RD: waits for the output frame to complete, then pulses done and returns to IDLE.
- Output path: combinational passthrough, always active regardless of state. m_axis_* = s_axis_fft_*, s_axis_fft_tready = m_axis_tready.
  - m_axis_index increments on each m_axis handshake and resets to 0 after the tlast handshake.
  - An out_done flag sets on the tlast handshake and clears on the next accepted start.
- Length 2^MAX_LOG2_LEN needs a MAX_LOG2_LEN+1 bit counter.
- start while busy is ignored.

Decomposition:
- Package fft_frame_pkg holds the state encoding, the config-word bit positions (NFFT_LSB=0, FWD_LSB=8) and the clogb2 function.
- Sub-module: axis_reg_slice, the single-stage register toward the core, with width CHANNELS*DATA_WIDTH+1.

Test Plan:
- log2_len=4, 16-beat input with tlast on beat 16 -> cfg_tdata=0x0304 (CHANNELS=2), 16 beats to the core with tlast on the 16th, err_trunc=0.
- log2_len=5, 10-beat input -> 10 data beats then 22 zero beats to the core, tlast on beat 32; s_axis_tready=0 during ZP.
- log2_len=3, 12-beat input -> 8 beats forwarded, err_trunc=1, 4 beats absorbed with tready=1, done after the output tlast.
- start with log2_len=2 or 14 -> err_len pulse for 1 cycle, busy stays 0, cfg_tvalid never asserts.
- Core output of 16 beats with random m_axis_tready stalls -> m_axis_index runs 0..15 with no skips, holds during stalls, done pulses once.
- aresetn low mid-WR -> next cycle all valids=0, busy=0; a following start runs a clean frame.
